// File: rtl/lab2_proc_fetch_drop_unit.sv
// lab2_proc_fetch_drop_unit: imem fetch front end with in-flight tracking, squash drop counting and instruction buffer
module lab2_proc_fetch_drop_unit #(
  parameter int p_max_inflight = 2,
  parameter int p_num_entries  = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  fetch_val,
  input  logic [31:0]                           fetch_addr,
  output logic                                  fetch_rdy,
  input  logic                                  squash,
  output logic                                  imem_reqstream_val,
  input  logic                                  imem_reqstream_rdy,
  output logic [31:0]                           imem_reqstream_msg_addr,
  input  logic                                  imem_respstream_val,
  output logic                                  imem_respstream_rdy,
  input  logic [31:0]                           imem_respstream_msg_data,
  output logic                                  inst_val,
  input  logic                                  inst_rdy,
  output logic [31:0]                           inst_data,
  output logic [$clog2(p_max_inflight+1)-1:0]   inflight
);
  localparam int IW = $clog2(p_max_inflight + 1);
  localparam int PW = $clog2(p_num_entries);
  localparam int CW = $clog2(p_num_entries + 1);
  logic [IW-1:0] inflight_q, inflight_d, drop_q, drop_d, live;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   buf_q [p_num_entries];
  logic          space_ok, req_fire, resp_fire, wr, pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(p_num_entries - 1)) ? '0 : p + PW'(1);
  endfunction
  // Space is reserved for every live in-flight request so the buffer can never overflow.
  always_comb begin
    live       = inflight_q - drop_q;
    space_ok   = squash || (int'(count_q) + int'(live) < p_num_entries);
    imem_reqstream_val = fetch_val && (inflight_q < IW'(p_max_inflight)) && space_ok;
    req_fire   = imem_reqstream_val && imem_reqstream_rdy;
    resp_fire  = imem_respstream_val;
    wr         = resp_fire && (drop_q == '0) && !squash;
    inst_val   = (count_q != '0) && !squash;
    pop        = inst_val && inst_rdy;
    inflight_d = inflight_q + IW'(req_fire) - IW'(resp_fire);
    drop_d     = squash ? inflight_q - IW'(resp_fire) : drop_q - IW'(resp_fire && (drop_q != '0));
    count_d    = squash ? '0 : count_q + CW'(wr) - CW'(pop);
    head_d     = squash ? '0 : pop ? inc(head_q) : head_q;
    tail_d     = squash ? '0 : wr ? inc(tail_q) : tail_q;
  end
  assign fetch_rdy               = req_fire;
  assign imem_reqstream_msg_addr = fetch_addr;
  assign imem_respstream_rdy     = 1'b1;
  assign inst_data               = buf_q[head_q];
  assign inflight                = inflight_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      for (int i = 0; i < p_num_entries; i++) buf_q[i] <= '0;
    end else begin
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      if (wr) buf_q[tail_q] <= imem_respstream_msg_data;
    end
  end
  assert property (@(posedge clk) disable iff (reset) !(wr && !pop && count_q == CW'(p_num_entries)));
  assert property (@(posedge clk) disable iff (reset) !(resp_fire && inflight_q == '0));
endmodule

// File: tb/tb_lab2_proc_fetch_drop_unit.sv
// tb_lab2_proc_fetch_drop_unit: random fetch/squash traffic on depth-4 and depth-3 instances vs an epoch-based reference model
module tb_lab2_proc_fetch_drop_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, n_done = 0;
  typedef struct { logic [31:0] addr; int ep; int due; } req_t;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int N = g ? 3 : 4;
    logic        reset, fetch_val, fetch_rdy, squash, req_val, req_rdy, resp_val, resp_rdy, inst_val, inst_rdy;
    logic [31:0] fetch_addr, req_addr, resp_data, inst_data, pc;
    logic [1:0]  inflight;
    req_t        mem[$];
    logic [31:0] exp_q[$];
    int          epoch = 0, cyc = 0, avail = 0;
    int          p_fetch, p_rdy, p_inst, p_squash, lat_min, lat_max;
    bit          run = 0;
    lab2_proc_fetch_drop_unit #(.p_max_inflight(2), .p_num_entries(N)) dut (
      .clk(clk), .reset(reset), .fetch_val(fetch_val), .fetch_addr(fetch_addr), .fetch_rdy(fetch_rdy),
      .squash(squash), .imem_reqstream_val(req_val), .imem_reqstream_rdy(req_rdy),
      .imem_reqstream_msg_addr(req_addr), .imem_respstream_val(resp_val), .imem_respstream_rdy(resp_rdy),
      .imem_respstream_msg_data(resp_data), .inst_val(inst_val), .inst_rdy(inst_rdy),
      .inst_data(inst_data), .inflight(inflight));
    function automatic string nm(input string s);
      return $sformatf("c%0d.%s", g, s);
    endfunction
    task automatic do_reset();
      run = 0;
      @(negedge clk);
      reset = 1; fetch_val = 0; squash = 0; resp_val = 0; inst_rdy = 0; req_rdy = 0;
      fetch_addr = 0; resp_data = 0;
      @(negedge clk);
      reset = 0;
      mem.delete(); exp_q.delete(); epoch = 0; avail = 0;
      #1;
      check(nm("rst_inst_val"), inst_val, 0);
      check(nm("rst_inst_data"), inst_data, 0);
      check(nm("rst_inflight"), inflight, 0);
      check(nm("rst_req_val"), req_val, 0);
      check(nm("rst_resp_rdy"), resp_rdy, 1);
      run = 1;
    endtask
    task automatic step();
      int live;
      bit exp_req;
      req_t r;
      @(negedge clk);
      cyc++;
      fetch_val = $urandom_range(99) < p_fetch;
      req_rdy   = $urandom_range(99) < p_rdy;
      inst_rdy  = $urandom_range(99) < p_inst;
      squash    = $urandom_range(99) < p_squash;
      if (squash) pc = $urandom & 32'hFFFF_FFFC;
      fetch_addr = pc;
      resp_val  = mem.size() > 0 && mem[0].due <= cyc;
      resp_data = resp_val ? ~mem[0].addr : 32'h0;
      #1;
      live = 0;
      foreach (mem[i]) if (mem[i].ep == epoch) live++;
      exp_req = fetch_val && mem.size() < 2 && (squash || exp_q.size() + live < N);
      check(nm("req_val"), req_val, exp_req);
      check(nm("fetch_rdy"), fetch_rdy, exp_req && req_rdy);
      check(nm("inflight"), inflight, mem.size());
      if (req_val) check(nm("req_addr"), req_addr, pc);
      avail = squash ? 0 : exp_q.size();
      if (squash) exp_q.delete();
      if (resp_val) begin
        r = mem.pop_front();
        if (!squash && r.ep == epoch) exp_q.push_back(~r.addr);
      end
      if (squash) epoch++;
      if (fetch_rdy) begin
        mem.push_back('{pc, epoch, cyc + int'($urandom_range(lat_max, lat_min))});
        pc += 4;
      end
    endtask
    task automatic knobs(input int f, input int rq, input int ir, input int sq, input int lo, input int hi);
      p_fetch = f; p_rdy = rq; p_inst = ir; p_squash = sq; lat_min = lo; lat_max = hi;
    endtask
    always @(negedge clk) begin
      #2;
      if (run) begin
        check(nm("inst_val"), inst_val, avail > 0);
        if (inst_val && inst_rdy) begin
          if (exp_q.size() == 0) check(nm("inst_unexpected"), inst_val, 0);
          else check(nm("inst_data"), inst_data, exp_q.pop_front());
        end
      end
    end
    initial begin
      do_reset();
      pc = 32'h200;
      knobs(100, 100, 100, 0, 1, 1);
      repeat (20) step();
      knobs(100, 100, 0, 0, 1, 1);
      repeat (12) step();
      check(nm("full_fetch_rdy"), fetch_rdy, 0);
      check(nm("full_inflight"), inflight, 0);
      check(nm("full_inst_val"), inst_val, 1);
      knobs(100, 100, 100, 0, 1, 1);
      repeat (12) step();
      knobs(100, 100, 100, 0, 3, 3);
      repeat (30) step();
      knobs(80, 70, 60, 8, 1, 4);
      repeat (600) step();
      do_reset();
      knobs(80, 70, 50, 10, 1, 3);
      repeat (150) step();
      knobs(0, 100, 100, 0, 1, 3);
      repeat (20) step();
      check(nm("drain_left"), exp_q.size(), 0);
      check(nm("drain_inflight"), inflight, 0);
      run = 0;
      n_done++;
    end
  end
  initial begin
    fork
      wait (n_done == 2);
      begin
        #200000;
        n_cmp++;
        n_bad++;
        $display("FAIL timeout: got %0d configs done expected 2", n_done);
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
